// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Architectural register file with an attached issue scoreboard.
// NREGS registers of WIDTH bits. The register at ZERO_REG is hardwired to zero
// and can never be marked pending. Two independent combinational read ports
// see a same-cycle writeback through a bypass path.
//
// Ports
//   clk                  rising-edge clock for all state
//   reset                synchronous, active-high; clears data, busy bits, count
//   wr_en/wr_addr/wr_data writeback: stores data and clears the pending mark
//   iss_en/iss_addr      issue: marks the destination register pending
//   rd_addr_a/rd_addr_b  read addresses
//   rd_data_a/rd_data_b  read data (bypassed from wr_data on an address match)
//   busy_a/busy_b        addressed register is pending (writeback hides it now)
//   pending_cnt          number of registers currently marked pending
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = NREGS - 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             busy_a,
  output logic             busy_b,
  output logic [AW:0]      pending_cnt
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic [WIDTH-1:0] w_mem [NREGS];
  logic [NREGS-1:0] w_busy;
  logic             w_wr_ok;
  logic             w_iss_ok;
  logic             w_set_new;
  logic             w_clr_real;
  logic             w_bypass_a;
  logic             w_bypass_b;
  logic [AW:0]      r_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == ZERO_REG) begin : g_zero
        assign w_mem[gi]  = '0;
        assign w_busy[gi] = 1'b0;
      end else begin : g_live
        logic [WIDTH-1:0] r_data;
        logic             r_busy;
        logic             w_wr_hit;
        logic             w_iss_hit;

        assign w_wr_hit  = wr_en  && (wr_addr  == AW'(gi));
        assign w_iss_hit = iss_en && (iss_addr == AW'(gi));

        always_ff @(posedge clk) begin
          if (reset) begin
            r_data <= '0;
            r_busy <= 1'b0;
          end else begin
            if (w_wr_hit) begin
              r_data <= wr_data;
            end
            // A re-issue in the same cycle as the writeback keeps the mark:
            // the writeback belongs to the older instruction.
            if (w_iss_hit) begin
              r_busy <= 1'b1;
            end else if (w_wr_hit) begin
              r_busy <= 1'b0;
            end
          end
        end

        assign w_mem[gi]  = r_data;
        assign w_busy[gi] = r_busy;
      end
    end
  endgenerate

  // Read ports: zero register always reads 0, bypass only outside reset.
  assign w_bypass_a = !reset && wr_en && (wr_addr == rd_addr_a) && (rd_addr_a != ZR);
  assign w_bypass_b = !reset && wr_en && (wr_addr == rd_addr_b) && (rd_addr_b != ZR);

  assign rd_data_a = (rd_addr_a == ZR) ? '0 : (w_bypass_a ? wr_data : w_mem[rd_addr_a]);
  assign rd_data_b = (rd_addr_b == ZR) ? '0 : (w_bypass_b ? wr_data : w_mem[rd_addr_b]);

  // A writeback hides the busy bit immediately unless the same register is
  // being re-issued this cycle.
  assign busy_a = !reset && w_busy[rd_addr_a]
                  && !(wr_en && (wr_addr == rd_addr_a) && !(iss_en && (iss_addr == rd_addr_a)));
  assign busy_b = !reset && w_busy[rd_addr_b]
                  && !(wr_en && (wr_addr == rd_addr_b) && !(iss_en && (iss_addr == rd_addr_b)));

  // Pending counter tracks net busy-bit changes: at most one set (new issue
  // to an idle register) and one genuine clear (writeback to a busy register
  // not re-issued) per edge.
  assign w_wr_ok    = wr_en  && (wr_addr  != ZR);
  assign w_iss_ok   = iss_en && (iss_addr != ZR);
  assign w_set_new  = w_iss_ok && !w_busy[iss_addr];
  assign w_clr_real = w_wr_ok && w_busy[wr_addr] && !(w_iss_ok && (iss_addr == wr_addr));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_set_new && !w_clr_real) begin
      r_cnt <= r_cnt + (AW+1)'(1);
    end else if (w_clr_real && !w_set_new) begin
      r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  assign pending_cnt = r_cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Directed scenarios followed by randomized traffic, compared against a
// behavioural model holding register contents in an array and pending marks
// in a bit vector (pending count = population count of that vector).
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

  localparam int W  = 64;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int ZR = 31;

  logic          clk;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          iss_en;
  logic [AW-1:0] iss_addr;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [W-1:0]  rd_data_a;
  logic [W-1:0]  rd_data_b;
  logic          busy_a;
  logic          busy_b;
  logic [AW:0]   pending_cnt;

  regfile_scoreboard #(.WIDTH(W), .NREGS(N), .ZERO_REG(ZR)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [W-1:0] m_mem [N];
  logic [N-1:0] m_busy;

  int checks   = 0;
  int failures = 0;

  // Observed values from the latest step, for directed constant checks
  logic [W-1:0] obs_a, obs_b;
  logic         obs_ba, obs_bb;
  logic [AW:0]  obs_cnt;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_data(input logic [AW-1:0] ra);
    if (ra == AW'(ZR))                           return '0;
    if (!reset && wr_en && wr_addr == ra)        return wr_data;
    return m_mem[ra];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] ra);
    if (reset || ra == AW'(ZR))                  return 1'b0;
    if (wr_en && wr_addr == ra && !(iss_en && iss_addr == ra)) return 1'b0;
    return m_busy[ra];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    m_busy = '0;
  endtask

  // One transaction: drive, check combinational outputs, clock, check count.
  task automatic step(input string tag, input logic r, input logic we,
                      input logic [AW-1:0] wa, input logic [W-1:0] wd,
                      input logic ie, input logic [AW-1:0] ia,
                      input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    reset = r; wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia; rd_addr_a = ra; rd_addr_b = rb;
    #1;
    obs_a = rd_data_a; obs_b = rd_data_b; obs_ba = busy_a; obs_bb = busy_b;
    check_val({tag, "_rd_a"},   rd_data_a, exp_data(ra));
    check_val({tag, "_rd_b"},   rd_data_b, exp_data(rb));
    check_val({tag, "_busy_a"}, W'(busy_a), W'(exp_busy(ra)));
    check_val({tag, "_busy_b"}, W'(busy_b), W'(exp_busy(rb)));
    @(posedge clk);
    if (r) begin
      model_clear();
    end else begin
      if (we && wa != AW'(ZR)) begin
        m_mem[wa]  = wd;
        m_busy[wa] = 1'b0;
      end
      if (ie && ia != AW'(ZR)) m_busy[ia] = 1'b1;
    end
    #1;
    obs_cnt = pending_cnt;
    check_val({tag, "_cnt"}, W'(pending_cnt), W'($countones(m_busy)));
    $display("txn %s rst=%0d wr=%0d@%0d iss=%0d@%0d ra=%0d rb=%0d cnt=%0d",
             tag, r, we, wa, ie, ia, ra, rb, pending_cnt);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    int sel;
    sel = int'($urandom % 8);
    if (sel == 0)             return AW'(ZR);
    if (sel == 1 || sel == 2) return AW'($urandom_range(0, N-1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step("rst", 1, 0, 0, 0, 0, 0, 0, 1);
    check_val("rst_cnt0", W'(obs_cnt), 0);

    // Write then read back
    step("w5", 0, 1, 5, 64'hDEAD_BEEF, 0, 0, 0, 0);
    step("r5", 0, 0, 0, 0, 0, 0, 5, 0);
    check_val("req034_data", obs_a, 64'hDEAD_BEEF);
    check_val("req034_busy", W'(obs_ba), 0);

    // Same-cycle bypass
    step("byp7", 0, 1, 7, 64'h1234, 0, 0, 0, 7);
    check_val("req035_byp", obs_b, 64'h1234);

    // Zero register
    step("zr", 0, 1, AW'(ZR), 64'hFFFF, 1, AW'(ZR), AW'(ZR), AW'(ZR));
    check_val("req036_data", obs_a, 0);
    check_val("req036_busy", W'(obs_ba), 0);
    check_val("req036_cnt", W'(obs_cnt), 0);

    // Pending counter sequence
    step("i1", 0, 0, 0, 0, 1, 1, 1, 0);
    check_val("req037_cnt1", W'(obs_cnt), 1);
    step("i2", 0, 0, 0, 0, 1, 2, 1, 0);
    check_val("req037_cnt2", W'(obs_cnt), 2);
    step("i3", 0, 0, 0, 0, 1, 3, 2, 0);
    check_val("req037_cnt3", W'(obs_cnt), 3);
    check_val("req037_busy2", W'(obs_ba), 1);
    step("wb2", 0, 1, 2, 64'h22, 0, 0, 2, 0);
    check_val("req037_busyclr", W'(obs_ba), 0);
    check_val("req037_cnt_after", W'(obs_cnt), 2);

    // Issue and writeback to the same busy register
    step("i4", 0, 0, 0, 0, 1, 4, 4, 0);
    check_val("req038_cnt_pre", W'(obs_cnt), 3);
    step("iw4", 0, 1, 4, 64'hABCD, 1, 4, 4, 0);
    check_val("req038_busy_same", W'(obs_ba), 1);
    check_val("req038_cnt", W'(obs_cnt), 3);
    step("r4", 0, 0, 0, 0, 0, 0, 4, 1);
    check_val("req038_data", obs_a, 64'hABCD);
    check_val("req038_busy", W'(obs_ba), 1);

    // Reset with pending regs (1,3,4) and a writeback in flight
    step("rstp", 1, 1, 1, 64'h55, 1, 6, 1, 4);
    check_val("req039_nobyp", obs_a, 0);
    check_val("req039_stored", obs_b, 64'hABCD);
    check_val("req039_busy", W'(obs_bb), 0);
    check_val("req039_cnt", W'(obs_cnt), 0);
    step("r4z", 0, 0, 0, 0, 0, 0, 4, 6);
    check_val("req039_data", obs_a, 0);
    check_val("req039_busy4", W'(obs_ba), 0);
    step("wb4plain", 0, 1, 4, 64'h9, 0, 0, 3, 4);
    check_val("req033_cnt", W'(obs_cnt), 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step("rnd", ($urandom % 64) == 0, ($urandom % 2) == 0, rnd_addr(),
           {$urandom, $urandom}, ($urandom % 3) != 0, rnd_addr(),
           rnd_addr(), rnd_addr());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width of each register.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers, a power of two and at least 4.
REQ-003 SHALL have parameter ZERO_REG, default NREGS-1, index of the hardwired-zero register.
REQ-004 SHALL derive AW = log2(NREGS) as the address width; it is not user-settable.
REQ-005 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-007 SHALL have port wr_en, input, 1 bit, writeback strobe.
REQ-008 SHALL have port wr_addr, input, AW bits, writeback destination register.
REQ-009 SHALL have port wr_data, input, WIDTH bits, writeback data.
REQ-010 SHALL have port iss_en, input, 1 bit, issue strobe; marks a destination pending.
REQ-011 SHALL have port iss_addr, input, AW bits, issued destination register.
REQ-012 SHALL have ports rd_addr_a and rd_addr_b, input, AW bits each, read addresses.
REQ-013 SHALL have ports rd_data_a and rd_data_b, output, WIDTH bits each, read data.
REQ-014 SHALL have ports busy_a and busy_b, output, 1 bit each, high when the addressed register is pending.
REQ-015 SHALL have port pending_cnt, output, AW+1 bits, number of registers currently marked pending.

Function
REQ-016 SHALL store NREGS-1 writable registers plus one hardwired-zero register at ZERO_REG.
REQ-017 SHALL write wr_data into register wr_addr at the clock edge when wr_en=1, reset=0 and wr_addr!=ZERO_REG.
REQ-018 SHALL drive read outputs combinationally with zero added latency; both ports are fully independent.
REQ-019 SHALL return all-zero data and busy=0 for any read of ZERO_REG, regardless of writes or issues to it.
REQ-020 SHALL bypass: when wr_en=1, reset=0 and rd_addr equals wr_addr (not ZERO_REG), rd_data SHALL equal wr_data in the same cycle.
REQ-021 SHALL hold one busy bit per register: set at the edge when iss_en=1 for iss_addr, cleared at the edge when wr_en=1 for wr_addr.
REQ-022 SHALL, when iss_en and wr_en target the same register in one cycle, leave its busy bit set (the new issue wins).
REQ-023 SHALL ignore issues to ZERO_REG; its busy bit SHALL never be set.
REQ-024 SHALL accept a writeback to a non-busy register: data is written and the busy state is unchanged.
REQ-025 SHALL accept an issue to an already-busy register: the bit stays set and pending_cnt is unchanged.
REQ-026 SHALL compute busy_x = busy[rd_addr_x] AND NOT (wr_en AND wr_addr==rd_addr_x AND NOT iss-same-register-this-cycle); a writeback clears visibility in the same cycle.
REQ-027 SHALL keep pending_cnt as a registered counter equal to the population count of the busy bits after each edge.
REQ-028 SHALL update pending_cnt at each edge by +1, -1 or 0 according to the net set/clear of busy bits in that edge; it never wraps.
REQ-029 SHALL never drive pending_cnt above NREGS-1.

Reset
REQ-030 SHALL, on a rising edge with reset=1, clear all registers to 0, all busy bits to 0 and pending_cnt to 0.
REQ-031 SHALL give reset priority over wr_en and iss_en in the same cycle; both strobes are discarded.
REQ-032 SHALL disable the bypass and force busy_a and busy_b to 0 while reset=1; rd_data shows stored contents.
REQ-033 SHALL make a reset asserted mid-operation, with registers pending, discard every pending mark; later writebacks to those registers are plain writes.

Verification
REQ-034 SHALL pass: reset, then write reg 5 = 0xDEAD_BEEF; next cycle read a=5 -> rd_data_a=0xDEAD_BEEF, busy_a=0.
REQ-035 SHALL pass: wr_en to reg 7 with 0x1234 while rd_addr_b=7 in the same cycle -> rd_data_b=0x1234 combinationally.
REQ-036 SHALL pass: write 0xFFFF to ZERO_REG and issue to ZERO_REG -> read gives 0, busy=0, pending_cnt=0.
REQ-037 SHALL pass: issue regs 1, 2, 3 on consecutive cycles -> pending_cnt 1, 2, 3; writeback reg 2 -> busy clears in that cycle, pending_cnt=2 at the next edge.
REQ-038 SHALL pass: iss_en and wr_en both on reg 4 in one cycle with reg 4 busy -> reg 4 stays busy, data updated, pending_cnt unchanged.
REQ-039 SHALL pass: reset with 3 regs pending and wr_en active -> all data 0, all busy 0, pending_cnt=0 after the edge.
